// File: rtl/data_ram_ctrl_pkg.sv
// data_ram_ctrl_pkg: shared bus widths for the data RAM controller
package data_ram_ctrl_pkg;

    localparam int DATA_BUS    = 32;
    localparam int ADDR_BUS    = 32;
    localparam int MEM_SEL_BUS = DATA_BUS / 8;

endpackage

// File: rtl/data_ram_ctrl.sv
// data_ram_ctrl: MEM-stage load/store controller for a req/addr_ok/data_ok bus
module data_ram_ctrl
    import data_ram_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_BUS,
    parameter int DATA_W = DATA_BUS,
    parameter int SEL_W  = MEM_SEL_BUS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              stall_in,
    input  logic              mem_read_flag_in,
    input  logic              mem_write_flag_in,
    input  logic [SEL_W-1:0]  mem_sel_in,
    input  logic [ADDR_W-1:0] mem_addr_in,
    input  logic [DATA_W-1:0] mem_write_data_in,
    output logic              ram_req,
    output logic              ram_we,
    output logic [SEL_W-1:0]  ram_sel,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic              ram_addr_ok,
    input  logic              ram_data_ok,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] ram_read_data_out,
    output logic              stall_request
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE,
        S_DISCARD
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_we;
    logic [SEL_W-1:0]  r_sel;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              w_access;
    logic              w_issue;
    logic              w_capture;

    // a flushed instruction never counts as an access; both flags set means store
    assign w_access  = (mem_read_flag_in | mem_write_flag_in) & ~flush;
    assign w_issue   = (r_state == S_IDLE) & w_access;
    assign w_capture = (r_state == S_WAIT) & ram_data_ok & ~flush & ~r_we;

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    // next state: flush abandons REQ outright, but a WAIT already on the bus must drain via DISCARD
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    w_next = w_access ? S_REQ : S_IDLE;
            S_REQ:     w_next = flush ? S_IDLE : (ram_addr_ok ? S_WAIT : S_REQ);
            S_WAIT:    w_next = ram_data_ok ? (flush ? S_IDLE : S_DONE) : (flush ? S_DISCARD : S_WAIT);
            S_DONE:    w_next = stall_in ? S_DONE : S_IDLE;
            S_DISCARD: w_next = ram_data_ok ? S_IDLE : S_DISCARD;
            default:   w_next = S_IDLE;
        endcase
    end

    // bus fields latch once at issue and stay stable for the whole request; load data latches on completion
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_we    <= 1'b0;
            r_sel   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            if (w_issue) begin
                r_we    <= mem_write_flag_in;
                r_sel   <= mem_sel_in;
                r_addr  <= mem_addr_in;
                r_wdata <= mem_write_data_in;
            end
            if (w_capture) r_rdata <= ram_rdata;
        end
    end

    assign ram_req           = r_state == S_REQ;
    assign ram_we            = r_we;
    assign ram_sel           = r_sel;
    assign ram_addr          = r_addr;
    assign ram_wdata         = r_wdata;
    assign ram_read_data_out = r_rdata;
    // gated by rst so a pending access cannot raise a stall while reset is held
    assign stall_request     = rst & (w_issue | (r_state == S_REQ) | (r_state == S_WAIT) |
                                      ((r_state == S_DISCARD) & w_access));

endmodule

// File: tb/tb_data_ram_ctrl.sv
// tb_data_ram_ctrl: randomized scoreboard bench with a word-memory reference model
module tb_data_ram_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0, stall_in = 1'b0, rd = 1'b0, wr = 1'b0;
    logic [3:0]  sel = '0;
    logic [31:0] addr = '0, wdata = '0;
    logic        ram_req, ram_we;
    logic [3:0]  ram_sel;
    logic [31:0] ram_addr, ram_wdata, rdo;
    logic        aok = 1'b0, dok = 1'b0;
    logic [31:0] rdata = '0;
    logic        stall_req;

    always #5 clk = ~clk;

    data_ram_ctrl dut (
        .clk(clk), .rst(rst), .flush(flush), .stall_in(stall_in),
        .mem_read_flag_in(rd), .mem_write_flag_in(wr), .mem_sel_in(sel),
        .mem_addr_in(addr), .mem_write_data_in(wdata),
        .ram_req(ram_req), .ram_we(ram_we), .ram_sel(ram_sel), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_addr_ok(aok), .ram_data_ok(dok), .ram_rdata(rdata),
        .ram_read_data_out(rdo), .stall_request(stall_req)
    );

    typedef struct {
        logic        rd, wr;
        logic [3:0]  sel, idx;
        logic [31:0] wdata;
        int          flush_at, aok_dly, dok_dly, exp_stall;
        logic        ns;
    } inst_t;

    typedef struct {
        logic [31:0] data;
        int          exp_stall;
    } exp_t;

    localparam int N = 300;

    exp_t        exp_q[$];
    inst_t       dir_q[$];
    inst_t       cur;
    int          vectors = 0, miscompares = 0;
    int          cur_id = 0, issued = 0, age = 0;
    logic        cur_valid = 1'b0, cur_we = 1'b0;
    logic [3:0]  cur_sel = '0;
    logic [31:0] cur_addr = '0, cur_wdata = '0;
    logic [31:0] ref_mem[16], slv_mem[16];
    logic [31:0] last_ld = '0, saved_ld = '0;
    logic        out = 1'b0, o_we = 1'b0;
    logic [3:0]  o_idx = '0, o_sel = '0;
    logic [31:0] o_wd = '0;
    int          o_dly = 0, dcnt = 0, acnt = 0;
    logic        s_stall, s_acc, s_hs, s_dok, s_flush, s_sin, s_we;
    logic [3:0]  s_sel;
    logic [31:0] s_a, s_wd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] addr_of(input logic [3:0] i);
        return (i[3] ? 32'h2000 : 32'h1000) + {27'd0, i[2:0], 2'b00};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] s);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // retirement data, request contents, request stability and stall counts
    initial begin
        int          seen_id = -1, stall_cnt = 0, req_cnt = 0;
        logic        p_req = 1'b0, p_we = 1'b0, acc;
        logic [3:0]  p_sel = '0;
        logic [31:0] p_addr = '0, p_wdata = '0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                p_req = 1'b0;
                continue;
            end
            if (cur_id != seen_id) begin
                seen_id = cur_id;
                stall_cnt = 0;
                req_cnt = 0;
            end
            if (ram_req) check("stall_during_req", {31'd0, stall_req}, 32'd1);
            if (ram_req && p_req) begin
                check("req_addr_stable", ram_addr, p_addr);
                check("req_wdata_stable", ram_wdata, p_wdata);
                check("req_sel_stable", {28'd0, ram_sel}, {28'd0, p_sel});
                check("req_we_stable", {31'd0, ram_we}, {31'd0, p_we});
            end
            if (ram_req && aok) begin
                req_cnt++;
                check("requests_per_access", req_cnt, 1);
                check("bus_we", {31'd0, ram_we}, {31'd0, cur_we});
                check("bus_addr", ram_addr, cur_addr);
                check("bus_sel", {28'd0, ram_sel}, {28'd0, cur_sel});
                check("bus_wdata", ram_wdata, cur_wdata);
            end
            acc = (rd | wr) & ~flush;
            if (acc && stall_req) stall_cnt++;
            if (acc && !stall_req && !stall_in) begin
                if (exp_q.size() == 0) begin
                    check("retire_without_issue", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("read_data_out", rdo, e.data);
                    if (e.exp_stall >= 0) check("stall_cycles", stall_cnt, e.exp_stall);
                end
            end
            p_req = ram_req;
            p_we = ram_we;
            p_sel = ram_sel;
            p_addr = ram_addr;
            p_wdata = ram_wdata;
        end
    end

    task automatic set_inst(input inst_t i);
        exp_t e;
        cur = i;
        cur_valid = 1'b1;
        rd = i.rd;
        wr = i.wr;
        sel = i.sel;
        addr = addr_of(i.idx);
        wdata = i.wdata;
        cur_we = i.wr;
        cur_sel = i.sel;
        cur_addr = addr;
        cur_wdata = i.wdata;
        if (!i.wr) begin
            saved_ld = last_ld;
            last_ld = ref_mem[i.idx];
        end else begin
            ref_mem[i.idx] = merge(ref_mem[i.idx], i.wdata, i.sel);
        end
        e.data = last_ld;
        e.exp_stall = i.exp_stall;
        exp_q.push_back(e);
    endtask

    task automatic next_inst();
        inst_t i;
        cur_id++;
        age = 0;
        acnt = 0;
        if (dir_q.size() != 0) begin
            set_inst(dir_q.pop_front());
        end else if (issued >= N || $urandom_range(0, 4) == 0) begin
            cur_valid = 1'b0;
            rd = 1'b0;
            wr = 1'b0;
            addr = $urandom;
            cur.flush_at = -1;
            cur.ns = 1'b0;
            if (issued < N) issued++;
        end else begin
            issued++;
            i.wr = $urandom_range(0, 1) == 1;
            i.rd = !i.wr || $urandom_range(0, 5) == 0;
            i.sel = 4'($urandom);
            i.idx = 4'($urandom);
            i.wdata = $urandom;
            i.flush_at = (!i.wr && $urandom_range(0, 3) == 0) ? $urandom_range(0, 5) : -1;
            i.aok_dly = $urandom_range(0, 3);
            i.dok_dly = $urandom_range(0, 3);
            i.exp_stall = -1;
            i.ns = 1'b0;
            set_inst(i);
        end
    endtask

    // one clock: sample at negedge, then update memory/pipeline and drive after the edge
    task automatic step();
        @(negedge clk);
        s_stall = stall_req;
        s_acc = (rd | wr) & ~flush;
        s_hs = ram_req & aok;
        s_dok = dok;
        s_flush = flush;
        s_sin = stall_in;
        s_we = ram_we;
        s_a = ram_addr;
        s_sel = ram_sel;
        s_wd = ram_wdata;
        @(posedge clk);
        #1;
        if (s_dok && out) begin
            if (o_we) slv_mem[o_idx] = merge(slv_mem[o_idx], o_wd, o_sel);
            out = 1'b0;
        end
        if (s_hs) begin
            out = 1'b1;
            o_we = s_we;
            o_idx = {s_a[13], s_a[4:2]};
            o_sel = s_sel;
            o_wd = s_wd;
            o_dly = cur.dok_dly;
            dcnt = 0;
            acnt = 0;
        end
        if (!cur_valid || s_flush || (s_acc && !s_stall && !s_sin)) next_inst();
        else age++;
        stall_in = cur.ns ? 1'b0 : ($urandom_range(0, 4) == 0);
        flush = 1'b0;
        if (cur_valid && cur.flush_at >= 0 && age >= cur.flush_at && !stall_in &&
            (age == 0 || (s_stall && !s_dok))) begin
            flush = 1'b1;
            void'(exp_q.pop_back());
            last_ld = saved_ld;
        end
        aok = 1'b0;
        dok = 1'b0;
        rdata = $urandom;
        if (ram_req && !flush) begin
            if (acnt >= cur.aok_dly) aok = 1'b1;
            else acnt++;
        end
        if (out) begin
            if (dcnt >= o_dly) begin
                dok = 1'b1;
                rdata = slv_mem[o_idx];
            end else begin
                dcnt++;
            end
        end else if (!ram_req && $urandom_range(0, 9) == 0) begin
            dok = 1'b1;
        end
    endtask

    function automatic inst_t mk(input logic r, input logic w, input logic [3:0] s, input logic [3:0] ix,
                                 input logic [31:0] wd, input int fa, input int ad, input int dd, input int es);
        inst_t i;
        i.rd = r;
        i.wr = w;
        i.sel = s;
        i.idx = ix;
        i.wdata = wd;
        i.flush_at = fa;
        i.aok_dly = ad;
        i.dok_dly = dd;
        i.exp_stall = es;
        i.ns = 1'b1;
        return i;
    endfunction

    initial begin
        int cyc = 0;
        for (int k = 0; k < 16; k++) begin
            ref_mem[k] = $urandom;
            slv_mem[k] = ref_mem[k];
        end
        ref_mem[1] = 32'hDEAD_BEEF;
        slv_mem[1] = 32'hDEAD_BEEF;
        cur.flush_at = -1;
        cur.ns = 1'b1;
        cur.dok_dly = 0;
        cur.aok_dly = 0;
        rd = 1'b1;
        wr = 1'b1;
        sel = 4'hF;
        addr = 32'h1234;
        wdata = 32'hFFFF_FFFF;
        #12;
        check("reset_ram_req", {31'd0, ram_req}, 32'd0);
        check("reset_ram_we", {31'd0, ram_we}, 32'd0);
        check("reset_ram_sel", {28'd0, ram_sel}, 32'd0);
        check("reset_ram_addr", ram_addr, 32'd0);
        check("reset_ram_wdata", ram_wdata, 32'd0);
        check("reset_read_data", rdo, 32'd0);
        check("reset_stall_request", {31'd0, stall_req}, 32'd0);
        rd = 1'b0;
        wr = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;

        dir_q.push_back(mk(1, 0, 4'hF, 4'd1, 32'h0, -1, 0, 0, 3));
        dir_q.push_back(mk(1, 0, 4'hF, 4'd1, 32'h0, -1, 0, 1, 4));
        dir_q.push_back(mk(0, 1, 4'h3, 4'd8, 32'h1234_5678, -1, 3, 0, 6));
        dir_q.push_back(mk(1, 0, 4'hF, 4'd8, 32'h0, -1, 0, 0, 3));
        dir_q.push_back(mk(1, 0, 4'hF, 4'd2, 32'h0, 2, 5, 0, -1));
        dir_q.push_back(mk(1, 0, 4'hF, 4'd2, 32'h0, -1, 0, 0, 3));
        dir_q.push_back(mk(1, 0, 4'hF, 4'd3, 32'h0, 3, 0, 4, -1));
        dir_q.push_back(mk(0, 1, 4'hC, 4'd5, 32'hA5A5_5A5A, -1, 0, 0, 6));
        dir_q.push_back(mk(1, 0, 4'hF, 4'd5, 32'h0, -1, 0, 0, 3));

        while (!(issued >= N && dir_q.size() == 0 && !cur_valid && !out) && cyc < 20000) begin
            step();
            cyc++;
        end
        if (cyc >= 20000) check("drain_timeout", 32'd1, 32'd0);
        check("scoreboard_empty", exp_q.size(), 32'd0);

        cur_id++;
        cur = mk(1, 0, 4'hF, 4'd2, 32'h0, -1, 0, 5, -1);
        cur_valid = 1'b1;
        age = 0;
        acnt = 0;
        rd = 1'b1;
        wr = 1'b0;
        sel = 4'hF;
        addr = addr_of(4'd2);
        cur_we = 1'b0;
        cur_sel = 4'hF;
        cur_addr = addr;
        cur_wdata = wdata;
        repeat (3) step();
        #2 rst = 1'b0;
        #1;
        check("async_rst_ram_req", {31'd0, ram_req}, 32'd0);
        check("async_rst_ram_we", {31'd0, ram_we}, 32'd0);
        check("async_rst_ram_sel", {28'd0, ram_sel}, 32'd0);
        check("async_rst_ram_addr", ram_addr, 32'd0);
        check("async_rst_ram_wdata", ram_wdata, 32'd0);
        check("async_rst_read_data", rdo, 32'd0);
        check("async_rst_stall", {31'd0, stall_req}, 32'd0);
        rd = 1'b0;
        cur_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (10) step();
        check("late_data_ok_ignored", rdo, 32'd0);
        check("idle_after_reset_req", {31'd0, ram_req}, 32'd0);
        check("idle_after_reset_stall", {31'd0, stall_req}, 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
